// File: rtl/uart_rx_packetizer_pkg.sv
// rtl/uart_rx_packetizer_pkg.sv - shared FIFO entry layout and default depth for the packetizer
package uart_rx_packetizer_pkg;

    localparam int ENTRY_W            = 9;
    localparam int LAST_BIT           = 8;
    localparam int DEPTH_LOG2_DEFAULT = 4;

    // FIFO entry packing: last flag above the data byte
    function automatic logic [ENTRY_W-1:0] make_entry(input logic last, input logic [7:0] data);
        return {last, data};
    endfunction

endpackage

// File: rtl/uart_pkt_fifo.sv
// rtl/uart_pkt_fifo.sv - 9-bit synchronous FIFO with explicit level counter and registered FWFT head
module uart_pkt_fifo
    import uart_rx_packetizer_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [ENTRY_W-1:0]    push_entry,
    input  logic                  ready,
    output logic                  push_ok,
    output logic [ENTRY_W-1:0]    head,
    output logic                  valid,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_next;
    logic [DEPTH_LOG2:0]   level_after_pop;
    logic [DEPTH_LOG2:0]   level_next;
    logic [ENTRY_W-1:0]    head_next;
    logic                  pop;
    logic                  full;

    // Accept/pop decisions and the next head; a push into an otherwise empty FIFO bypasses storage
    always_comb begin
        full            = (level == FULL_LVL);
        pop             = valid && ready;
        push_ok         = push && (!full || pop);
        rd_next         = pop ? rd_ptr + 1'b1 : rd_ptr;
        level_after_pop = pop ? level - 1'b1 : level;
        level_next      = push_ok ? level_after_pop + 1'b1 : level_after_pop;
        head_next       = '0;
        if (level_next != '0) begin
            if (push_ok && level_after_pop == '0) begin
                head_next = push_entry;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // Entry storage, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers, level and the registered head/valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head   <= '0;
            valid  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            level  <= level_next;
            head   <= head_next;
            valid  <= (level_next != '0);
        end
    end

endmodule

// File: rtl/uart_rx_packetizer.sv
// rtl/uart_rx_packetizer.sv - hold slot, overflow flag and optional stats (UART_RX_PKT_STATS_EN) ahead of the packet FIFO
module uart_rx_packetizer
    import uart_rx_packetizer_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_data_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_endofpacket,
    output logic [7:0]            m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clr
`ifdef UART_RX_PKT_STATS_EN
    ,
    output logic [CNT_W-1:0]      pkt_count,
    output logic [CNT_W-1:0]      drop_count
`endif
);

    logic                hold_v;
    logic [7:0]          hold_d;
    logic                push_req;
    logic [ENTRY_W-1:0]  push_entry;
    logic                push_ok;
    logic                drop;
    logic [ENTRY_W-1:0]  head;

    // Any receiver event flushes the held byte; end-of-packet decides that it is the last one
    always_comb begin
        push_req   = hold_v && (rx_data_ready || rx_endofpacket);
        push_entry = make_entry(rx_endofpacket, hold_d);
        drop       = push_req && !push_ok;
    end

    // Hold slot: a new byte replaces the flushed one; a bare end-of-packet empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v <= 1'b0;
            hold_d <= '0;
        end else if (rx_data_ready) begin
            hold_v <= 1'b1;
            hold_d <= rx_data;
        end else if (rx_endofpacket) begin
            hold_v <= 1'b0;
        end
    end

    // Sticky overflow; a drop wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    uart_pkt_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_req),
        .push_entry (push_entry),
        .ready      (m_ready),
        .push_ok    (push_ok),
        .head       (head),
        .valid      (m_valid),
        .level      (level)
    );

    assign m_data = head[7:0];
    assign m_last = head[LAST_BIT];

`ifdef UART_RX_PKT_STATS_EN
    // Saturating packet and drop counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok && push_entry[LAST_BIT] && pkt_count != '1) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (drop && drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
